// File: rtl/square_arbiter.sv
// square_arbiter: shares one signed 16x16 squarer among NUM_REQ requesters; `SQUARE_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: 1 clock from req_valid&req_ready to resp_valid; one result per cycle while resp_ready=1.
// Backpressure: a held result (resp_valid & ~resp_ready) or enable low blocks every grant; result stays stable.
`timescale 1ns/1ps
module square_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*16-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    resp_valid,
  output logic [30:0]             resp_data,
  output logic [ID_W-1:0]         resp_id,
  input  logic                    resp_ready,
  output logic                    busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic [ID_W-1:0]    grant_idx;
  logic signed [15:0] operand;
  logic signed [30:0] operand_ext;
  logic signed [30:0] square;

`ifdef SQUARE_ARB_RR_EN
  logic [ID_W-1:0] ptr;
  logic            found;
  int              cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= ID_W'(NUM_REQ - 1);
    else if (accept)
      ptr <= grant_idx;
  end

  // Search starts just after the last winner and wraps, so every active requester is reached within NUM_REQ grants.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end
`else
  // Scan high to low so the lowest asserted index is the final assignment.
  always_comb begin
    grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[ID_W'(k)])
        grant_idx = ID_W'(k);
    end
  end
`endif

  // rst_n gates accept so no requester sees a grant while the block is held in reset.
  assign accept    = rst_n & enable & (|req_valid) & (~resp_valid | resp_ready);
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign busy      = resp_valid | (|req_valid);

  always_comb begin
    operand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k))
        operand = req_data[16*k +: 16];
    end
  end

  // Product of two sign-extended operands fits in 31 bits: worst case (-32768)^2 = 2^30.
  assign operand_ext = 31'(operand);
  assign square      = operand_ext * operand_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (!accept && resp_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    resp_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_data <= '0;
      resp_id   <= '0;
    end else if (accept) begin
      resp_data <= square;
      resp_id   <= grant_idx;
    end
  end

endmodule

// File: tb/tb_square_arbiter.sv
// Scoreboard bench for square_arbiter: expectations queued at grant time, popped when the response is seen.
`timescale 1ns/1ps
module tb_square_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
`ifdef SQUARE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        resp_ready = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [30:0] resp_data;
  logic [1:0]  resp_id;
  logic        busy;

  typedef struct packed {
    logic [1:0]  id;
    logic [30:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  square_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] sq(input logic [15:0] v);
    longint x;
    x = longint'($signed(v));
    x = x * x;
    return x[30:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    enable = 1'b1; resp_ready = 1'b1; req_valid = 4'b1111;
    req_data = 64'h0004_0003_0002_0001;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid, resp_id, resp_data, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b id=%0d data=%h ready=%b, want all zero", resp_valid, resp_id, resp_data, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got ready=%b v=%0b, want ready=0000 v=0", req_ready, resp_valid);
    end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    exp_t e; int g; logic [3:0] oh;
    step();
    enable = 1'b1; resp_ready = 1'b1; req_valid = 4'b1111;
    req_data = {16'hFFF9, 16'd300, 16'hFF85, 16'd5};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      g = RR ? (c % 4) : 0;
      oh = 4'b0001 << g;
      n_checks++;
      if (req_ready !== oh) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b, want %b", c, req_ready, oh);
      end
      if (c > 0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rr_resp[%0d]: response with empty scoreboard", c);
        end else begin
          e = sb.pop_front();
          if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
            n_fail++;
            $display("FAIL rr_resp[%0d]: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", c, resp_valid, resp_id, resp_data, e.id, e.data);
          end
        end
      end
      e.id = 2'(g); e.data = sq(req_data[16*g +: 16]);
      sb.push_back(e);
      step();
    end
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL rr_last: response with empty scoreboard");
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL rr_last: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", resp_valid, resp_id, resp_data, e.id, e.data);
      end
    end
  endtask

  task automatic test_single();
    exp_t e;
    step();
    enable = 1'b1; resp_ready = 1'b1; req_valid = 4'b0100;
    req_data = '0; req_data[47:32] = 16'h0003;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_grant: got %b, want 0100", req_ready);
    end
    e.id = 2'd2; e.data = 31'd9;
    sb.push_back(e);
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL single_resp: response with empty scoreboard");
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL single_resp: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", resp_valid, resp_id, resp_data, e.id, e.data);
      end
    end
    step();
    @(negedge clk);
    n_checks++;
    if ({resp_valid, resp_id, resp_data} !== {1'b0, 2'd2, 31'd9}) begin
      n_fail++;
      $display("FAIL drain_hold: got v=%0b id=%0d data=%h, want v=0 id=2 data=9", resp_valid, resp_id, resp_data);
    end
  endtask

  task automatic test_extremes();
    exp_t e;
    int         idx [3] = '{3, 0, 1};
    logic [15:0] op [3] = '{16'hFFFF, 16'h8000, 16'h7FFF};
    logic [30:0] res [3] = '{31'h0000_0001, 31'h4000_0000, 31'h3FFF_0001};
    for (int t = 0; t < 3; t++) begin
      step();
      req_valid = 4'b0001 << idx[t];
      req_data = '0; req_data[16*idx[t] +: 16] = op[t];
      @(negedge clk);
      e.id = 2'(idx[t]); e.data = res[t];
      sb.push_back(e);
      step();
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL extreme[%0d]: response with empty scoreboard", t);
      end else begin
        e = sb.pop_front();
        if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
          n_fail++;
          $display("FAIL extreme[%0d]: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", t, resp_valid, resp_id, resp_data, e.id, e.data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    step();
    resp_ready = 1'b0; req_valid = 4'b0010;
    req_data = '0; req_data[31:16] = 16'hABCD;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_first_grant: got %b, want 0010", req_ready);
    end
    e.id = 2'd1; e.data = sq(16'hABCD);
    sb.push_back(e);
    step();
    req_data[31:16] = 16'h0102;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req_ready, resp_valid, resp_id, resp_data} !== {4'b0000, 1'b1, 2'd1, sq(16'hABCD)}) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: got ready=%b v=%0b id=%0d data=%h, want ready=0000 v=1 id=1 data=%h", k, req_ready, resp_valid, resp_id, resp_data, sq(16'hABCD));
      end
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL bp_release_grant: got %b, want 0010", req_ready);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL bp_resp0: response with empty scoreboard");
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL bp_resp0: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", resp_valid, resp_id, resp_data, e.id, e.data);
      end
    end
    e.id = 2'd1; e.data = sq(16'h0102);
    sb.push_back(e);
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL bp_resp1: response with empty scoreboard");
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL bp_resp1: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", resp_valid, resp_id, resp_data, e.id, e.data);
      end
    end
  endtask

  task automatic test_enable();
    exp_t e; int g; logic [3:0] oh;
    step();
    enable = 1'b1; resp_ready = 1'b0; req_valid = 4'b1111;
    req_data = {16'd40, 16'hFFE0, 16'd17, 16'd2};
    @(negedge clk);
    g = RR ? 2 : 0;
    oh = 4'b0001 << g;
    n_checks++;
    if (req_ready !== oh) begin
      n_fail++; $display("FAIL en_first_grant: got %b, want %b", req_ready, oh);
    end
    e.id = 2'(g); e.data = sq(req_data[16*g +: 16]);
    sb.push_back(e);
    step();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0000 || resp_valid !== 1'b1) begin
        n_fail++; $display("FAIL en_low[%0d]: got ready=%b v=%0b, want ready=0000 v=1", k, req_ready, resp_valid);
      end
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL en_drain: got ready=%b queue=%0d, want ready=0000 queue>0", req_ready, sb.size());
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL en_drain: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", resp_valid, resp_id, resp_data, e.id, e.data);
      end
    end
    step();
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL en_drained: got v=%0b ready=%b, want v=0 ready=0000", resp_valid, req_ready);
    end
    step();
    enable = 1'b1;
    @(negedge clk);
    g = RR ? 3 : 0;
    oh = 4'b0001 << g;
    n_checks++;
    if (req_ready !== oh) begin
      n_fail++; $display("FAIL en_resume_grant: got %b, want %b", req_ready, oh);
    end
    e.id = 2'(g); e.data = sq(req_data[16*g +: 16]);
    sb.push_back(e);
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL en_resume_resp: response with empty scoreboard");
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL en_resume_resp: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", resp_valid, resp_id, resp_data, e.id, e.data);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    step();
    enable = 1'b1; resp_ready = 1'b0; req_valid = 4'b0010;
    req_data = {16'd9, 16'd8, 16'h1234, 16'hFFFD};
    @(negedge clk);
    step();
    req_valid = 4'b1111;
    @(negedge clk);
    n_checks++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd1, sq(16'h1234)}) begin
      n_fail++;
      $display("FAIL mid_loaded: got v=%0b id=%0d data=%h, want v=1 id=1 data=%h", resp_valid, resp_id, resp_data, sq(16'h1234));
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({resp_valid, resp_id, resp_data, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got v=%0b id=%0d data=%h ready=%b, want all zero", resp_valid, resp_id, resp_data, req_ready);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL post_reset_grant: got %b, want 0001", req_ready);
    end
    e.id = 2'd0; e.data = sq(16'hFFFD);
    sb.push_back(e);
    step();
    req_valid = '0; resp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL post_reset_resp: response with empty scoreboard");
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
        n_fail++;
        $display("FAIL post_reset_resp: got v=%0b id=%0d data=%h, want v=1 id=%0d data=%h", resp_valid, resp_id, resp_data, e.id, e.data);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries left, want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_extremes();
    test_backpressure();
    test_enable();
    test_reset_mid();
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
